// File: rtl/register_file.sv
// register_file: eight WIDTH-bit registers (R1-R4 general purpose, S1-S4 scratch)
// with a shared per-edge operation (FunSel) applied to every enabled register
// and two independent combinational read ports (OutA / OutB).
//
// Register index map used throughout this file:
//   0..3 = R1..R4 (enables RegSel[3:0]),  4..7 = S1..S4 (enables ScrSel[3:0])
// which is exactly the OutASel / OutBSel encoding, so the read select indexes
// the storage array directly.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> a load (FunSel=010) into the register currently selected on a
//                read port is forwarded combinationally from I to that port.
//   undefined -> reads always show the stored value (one-cycle write latency).
module register_file #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic [3:0]       RegSel,
    input  logic [3:0]       ScrSel,
    input  logic [2:0]       OutASel,
    input  logic [2:0]       OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB
);

    // Byte operations split the word into a low and a high half.
    localparam int HALF = WIDTH / 2;

    // FunSel encodings
    localparam logic [2:0] FS_DEC      = 3'b000;
    localparam logic [2:0] FS_INC      = 3'b001;
    localparam logic [2:0] FS_LOAD     = 3'b010;
    localparam logic [2:0] FS_CLEAR    = 3'b011;
    localparam logic [2:0] FS_LO_ZEXT  = 3'b100;
    localparam logic [2:0] FS_LO_KEEP  = 3'b101;
    localparam logic [2:0] FS_HI_KEEP  = 3'b110;
    localparam logic [2:0] FS_LO_SEXT  = 3'b111;

    // Storage and per-register next values
    logic [WIDTH-1:0] r_regs [0:7];
    logic [WIDTH-1:0] w_next [0:7];
    logic [7:0]       w_en;

    // Next value of one register for a given operation; increment and
    // decrement wrap naturally modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] f_apply(
        input logic [2:0]       fs,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] v;
        v = q;
        case (fs)
            FS_DEC:     v = q - WIDTH'(1);
            FS_INC:     v = q + WIDTH'(1);
            FS_LOAD:    v = d;
            FS_CLEAR:   v = '0;
            FS_LO_ZEXT: v = {{(WIDTH - HALF){1'b0}}, d[HALF-1:0]};
            FS_LO_KEEP: v = {q[WIDTH-1:HALF], d[HALF-1:0]};
            FS_HI_KEEP: v = {d[HALF-1:0], q[HALF-1:0]};
            FS_LO_SEXT: v = {{(WIDTH - HALF){d[HALF-1]}}, d[HALF-1:0]};
            default:    v = q;
        endcase
        return v;
    endfunction

    // Combined enable vector, ordered to match the register index map.
    assign w_en = {ScrSel, RegSel};

    // Compute the candidate next value of every register from its own current value.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_next[k] = f_apply(FunSel, r_regs[k], I);
        end
    end

    // Register bank: async clear, otherwise only enabled registers update.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < 8; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (w_en[k]) begin
                    r_regs[k] <= w_next[k];
                end
            end
        end
    end

`ifdef RF_BYPASS_EN
    logic w_fwd_a;
    logic w_fwd_b;

    // Forward only plain loads; gated by Reset so outputs read zero while in reset.
    always_comb begin
        w_fwd_a = Reset && w_en[OutASel] && (FunSel == FS_LOAD);
        w_fwd_b = Reset && w_en[OutBSel] && (FunSel == FS_LOAD);
    end

    // Read ports with write forwarding.
    always_comb begin
        OutA = w_fwd_a ? I : r_regs[OutASel];
        OutB = w_fwd_b ? I : r_regs[OutBSel];
    end
`else
    // Read ports: stored value only, so a write appears the cycle after its edge.
    always_comb begin
        OutA = r_regs[OutASel];
        OutB = r_regs[OutBSel];
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios plus randomized traffic, all
// checked against a behavioural model of the eight registers. Stimulus pushes
// expected read-port values into a queue and strobes; a separate monitor pops
// and compares against the DUT outputs.
module tb_register_file;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] I;
    logic [2:0]   FunSel;
    logic [3:0]   RegSel;
    logic [3:0]   ScrSel;
    logic [2:0]   OutASel;
    logic [2:0]   OutBSel;
    logic [W-1:0] OutA;
    logic [W-1:0] OutB;

    always #5 Clock = ~Clock;

    register_file #(.WIDTH(W)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .I      (I),
        .FunSel (FunSel),
        .RegSel (RegSel),
        .ScrSel (ScrSel),
        .OutASel(OutASel),
        .OutBSel(OutBSel),
        .OutA   (OutA),
        .OutB   (OutB)
    );

    // ---------------- reference model ----------------
    // m[0..3] = R1..R4, m[4..7] = S1..S4
    logic [W-1:0] m [0:7];

    function automatic logic [W-1:0] model_op(input logic [2:0] fs,
                                              input logic [W-1:0] q,
                                              input logic [W-1:0] d);
        int unsigned qi;
        int unsigned lo;
        qi = int'(q);
        lo = int'(d) % 256;
        case (fs)
            3'd0: return W'((qi + 65535) % 65536);
            3'd1: return W'((qi + 1) % 65536);
            3'd2: return d;
            3'd3: return '0;
            3'd4: return W'(lo);
            3'd5: return W'((qi / 256) * 256 + lo);
            3'd6: return W'(lo * 256 + qi % 256);
            default: return W'((lo >= 128) ? (65280 + lo) : lo);
        endcase
    endfunction

    function automatic logic [W-1:0] model_read(input logic [2:0] sel);
        if (!Reset) return '0;
`ifdef RF_BYPASS_EN
        if (FunSel == 3'd2 && (sel < 4 ? RegSel[sel[1:0]] : ScrSel[sel[1:0]]))
            return I;
`endif
        return m[sel];
    endfunction

    task automatic model_edge();
        if (Reset) begin
            for (int k = 0; k < 8; k++) begin
                if (k < 4 ? RegSel[k] : ScrSel[k-4]) m[k] = model_op(FunSel, m[k], I);
            end
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m[k] = '0;
    endtask

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    string          name_q[$];
    logic           mon_strobe = 1'b0;
    int             n_checks = 0;
    int             n_pass = 0;

    // Expect current model read values on both ports and hand them to the monitor.
    task automatic expect_now(input string nm);
        exp_q.push_back({model_read(OutASel), model_read(OutBSel)});
        name_q.push_back(nm);
        mon_strobe = 1'b1;
        #1;
        mon_strobe = 1'b0;
    endtask

    // Monitor: pop expected pair and compare with DUT read ports.
    initial begin
        logic [2*W-1:0] e;
        string nm;
        forever begin
            @(posedge mon_strobe);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL monitor_underflow: strobe with empty queue");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if (OutA === e[2*W-1:W]) n_pass++;
                else $display("FAIL %s OutA: got %h expected %h (sel %0d)", nm, OutA, e[2*W-1:W], OutASel);
                n_checks++;
                if (OutB === e[W-1:0]) n_pass++;
                else $display("FAIL %s OutB: got %h expected %h (sel %0d)", nm, OutB, e[W-1:0], OutBSel);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge: drive, check pre-edge outputs, clock, return at next negedge.
    task automatic step(input logic [2:0] fs, input logic [3:0] rs, input logic [3:0] ss,
                        input logic [W-1:0] d, input logic [2:0] a, input logic [2:0] b,
                        input string nm);
        FunSel = fs; RegSel = rs; ScrSel = ss; I = d; OutASel = a; OutBSel = b;
        #1;
        expect_now(nm);
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
    endtask

    // Observe only: no enables, check ports.
    task automatic peek(input logic [2:0] a, input logic [2:0] b, input string nm);
        FunSel = 3'd3; RegSel = 4'h0; ScrSel = 4'h0; OutASel = a; OutBSel = b;
        #1;
        expect_now(nm);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1'b0; I = '0; FunSel = 3'd3; RegSel = '0; ScrSel = '0;
        OutASel = 3'd0; OutBSel = 3'd7;
        model_clear();
        #2;
        expect_now("reset_state");
        @(negedge Clock);
        Reset = 1'b1;

        // Async reset after loading R1
        step(3'd2, 4'b0001, 4'b0000, 16'h1234, 3'd0, 3'd4, "load_r1");
        peek(3'd0, 3'd4, "r1_loaded");
        #1;
        Reset = 1'b0;
        model_clear();
        #1;
        expect_now("reset_async");
        FunSel = 3'd1; RegSel = 4'hF; ScrSel = 4'hF;
        @(posedge Clock);
        #1;
        expect_now("reset_blocks_write");
        @(negedge Clock);
        Reset = 1'b1;
        step(3'd1, 4'b0001, 4'b0000, 16'h0000, 3'd0, 3'd1, "first_write_after_reset");
        peek(3'd0, 3'd1, "r1_inc_from_zero");

        // Wrap-around on R2
        step(3'd2, 4'b0010, 4'b0000, 16'hFFFF, 3'd1, 3'd0, "load_r2_ffff");
        step(3'd1, 4'b0010, 4'b0000, 16'h0000, 3'd1, 3'd0, "inc_r2");
        peek(3'd1, 3'd0, "r2_wrap_up");
        step(3'd0, 4'b0010, 4'b0000, 16'h0000, 3'd1, 3'd0, "dec_r2");
        peek(3'd1, 3'd0, "r2_wrap_down");

        // Byte operations on S3
        step(3'd2, 4'b0000, 4'b0100, 16'hABCD, 3'd6, 3'd1, "load_s3");
        step(3'd7, 4'b0000, 4'b0100, 16'h0080, 3'd6, 3'd1, "sext_s3");
        peek(3'd6, 3'd1, "s3_ff80");
        step(3'd6, 4'b0000, 4'b0100, 16'h0012, 3'd6, 3'd1, "hi_s3");
        peek(3'd6, 3'd1, "s3_1280");
        step(3'd5, 4'b0000, 4'b0100, 16'h0034, 3'd6, 3'd1, "lo_s3");
        peek(3'd6, 3'd1, "s3_1234");
        step(3'd4, 4'b0000, 4'b0100, 16'hBEEF, 3'd6, 3'd1, "zext_s3");
        peek(3'd6, 3'd1, "s3_00ef");

        // Multi-write then disabled clear
        step(3'd2, 4'b1111, 4'b1111, 16'h5A5A, 3'd0, 3'd7, "load_all");
        for (int k = 0; k < 4; k++) peek(3'(2*k), 3'(2*k+1), "all_5a5a");
        step(3'd3, 4'b0000, 4'b0000, 16'h0000, 3'd2, 3'd5, "clear_disabled");
        for (int k = 0; k < 4; k++) peek(3'(2*k), 3'(2*k+1), "still_5a5a");

        // Dual read
        step(3'd2, 4'b1000, 4'b0000, 16'h0001, 3'd3, 3'd4, "load_r4");
        step(3'd2, 4'b0000, 4'b0001, 16'h8000, 3'd3, 3'd4, "load_s1");
        peek(3'd3, 3'd4, "dual_read");
        peek(3'd3, 3'd3, "same_reg_both");

        // Bypass / latency on R1 (pre-edge expectation depends on build)
        step(3'd2, 4'b0001, 4'b0000, 16'h00FF, 3'd0, 3'd0, "r1_load_pre_edge");
        peek(3'd0, 3'd5, "r1_load_post_edge");
        step(3'd1, 4'b0001, 4'b0000, 16'h1111, 3'd0, 3'd0, "inc_not_forwarded");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 W'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 "random");
        end
        for (int k = 0; k < 8; k++) peek(3'(k), 3'(7 - k), "final_sweep");

        // Drain (bounded)
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
